// File: rtl/rps_match_ctrl_if.sv
// Handshake and status bundle for the stone/paper/scissors match controller.
// The slave modport is the controller's view; master is the surrounding tile.
interface rps_match_ctrl_if #(
  parameter int unsigned SCORE_W = 4
) ();
  logic               start;
  logic               abort;
  logic               p1_valid;
  logic [1:0]         p1_move;
  logic               p1_ready;
  logic               p2_valid;
  logic [1:0]         p2_move;
  logic               p2_ready;
  logic               round_done;
  logic [1:0]         round_result;
  logic [SCORE_W-1:0] p1_score;
  logic [SCORE_W-1:0] p2_score;
  logic [SCORE_W-1:0] round_cnt;
  logic               match_done;
  logic [1:0]         match_winner;
  logic               err_invalid;
  logic [2:0]         state_o;

  modport master (
    output start, abort, p1_valid, p1_move, p2_valid, p2_move,
    input  p1_ready, p2_ready, round_done, round_result, p1_score, p2_score, round_cnt,
    input  match_done, match_winner, err_invalid, state_o
  );

  modport slave (
    input  start, abort, p1_valid, p1_move, p2_valid, p2_move,
    output p1_ready, p2_ready, round_done, round_result, p1_score, p2_score, round_cnt,
    output match_done, match_winner, err_invalid, state_o
  );
endinterface

// File: rtl/rps_match_ctrl.sv
// Multi-round stone/paper/scissors match controller: collects one move per player per
// round, judges it, keeps scores and ends the match on a win count or round limit.
module rps_match_ctrl #(
  parameter int unsigned ROUNDS_TO_WIN = 3,
  parameter int unsigned MAX_ROUNDS    = 9,
  parameter int unsigned SCORE_W       = 4,
  parameter int unsigned TIMEOUT_CYC   = 255
) (
  input logic              clk,
  input logic              reset,
  rps_match_ctrl_if.slave  bus
);

  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StCollect = 3'd1,
    StJudge   = 3'd2,
    StCheck   = 3'd3,
    StDone    = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic               start_q;
  logic               p1_have_q, p1_have_d, p2_have_q, p2_have_d;
  logic [1:0]         p1_mv_q, p1_mv_d, p2_mv_q, p2_mv_d;
  logic [TW-1:0]      tmo_q, tmo_d;
  logic [SCORE_W-1:0] p1_score_q, p1_score_d, p2_score_q, p2_score_d;
  logic [SCORE_W-1:0] round_cnt_q, round_cnt_d;
  logic [1:0]         result_q, result_d;
  logic               err_q, err_d;

  logic       start_rise;
  logic       p1_rdy, p2_rdy, p1_cap, p2_cap, p1_bad, p2_bad;
  logic       p1_beats;
  logic [1:0] verdict;

  assign start_rise = bus.start & ~start_q;
  assign p1_rdy     = (state_q == StCollect) & ~p1_have_q;
  assign p2_rdy     = (state_q == StCollect) & ~p2_have_q;
  assign p1_cap     = p1_rdy & bus.p1_valid & (bus.p1_move != 2'b11);
  assign p2_cap     = p2_rdy & bus.p2_valid & (bus.p2_move != 2'b11);
  assign p1_bad     = p1_rdy & bus.p1_valid & (bus.p1_move == 2'b11);
  assign p2_bad     = p2_rdy & bus.p2_valid & (bus.p2_move == 2'b11);

  assign p1_beats = ((p1_mv_q == 2'b00) && (p2_mv_q == 2'b10)) ||
                    ((p1_mv_q == 2'b01) && (p2_mv_q == 2'b00)) ||
                    ((p1_mv_q == 2'b10) && (p2_mv_q == 2'b01));

  // An absent move forfeits; both absent is a tie.
  always_comb begin
    verdict = 2'b00;
    if (p1_have_q && p2_have_q) begin
      if (p1_mv_q != p2_mv_q) verdict = p1_beats ? 2'b01 : 2'b10;
    end else if (p1_have_q) begin
      verdict = 2'b01;
    end else if (p2_have_q) begin
      verdict = 2'b10;
    end
  end

  always_comb begin
    state_d     = state_q;
    p1_have_d   = p1_have_q;
    p2_have_d   = p2_have_q;
    p1_mv_d     = p1_mv_q;
    p2_mv_d     = p2_mv_q;
    tmo_d       = tmo_q;
    p1_score_d  = p1_score_q;
    p2_score_d  = p2_score_q;
    round_cnt_d = round_cnt_q;
    result_d    = result_q;
    err_d       = 1'b0;
    if (bus.abort) begin
      state_d     = StIdle;
      p1_have_d   = 1'b0;
      p2_have_d   = 1'b0;
      p1_mv_d     = 2'b00;
      p2_mv_d     = 2'b00;
      tmo_d       = '0;
      p1_score_d  = '0;
      p2_score_d  = '0;
      round_cnt_d = '0;
      result_d    = 2'b00;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start_rise) begin
            state_d     = StCollect;
            p1_have_d   = 1'b0;
            p2_have_d   = 1'b0;
            tmo_d       = '0;
            p1_score_d  = '0;
            p2_score_d  = '0;
            round_cnt_d = '0;
            result_d    = 2'b00;
          end
        end
        StCollect: begin
          if (p1_cap) begin
            p1_have_d = 1'b1;
            p1_mv_d   = bus.p1_move;
          end
          if (p2_cap) begin
            p2_have_d = 1'b1;
            p2_mv_d   = bus.p2_move;
          end
          err_d = p1_bad | p2_bad;
          tmo_d = tmo_q + TW'(1);
          if ((p1_have_d && p2_have_d) || (tmo_q == TW'(TIMEOUT_CYC - 1))) state_d = StJudge;
        end
        StJudge: begin
          result_d    = verdict;
          round_cnt_d = round_cnt_q + SCORE_W'(1);
          if (verdict == 2'b01) p1_score_d = p1_score_q + SCORE_W'(1);
          if (verdict == 2'b10) p2_score_d = p2_score_q + SCORE_W'(1);
          state_d = StCheck;
        end
        StCheck: begin
          if ((p1_score_q == SCORE_W'(ROUNDS_TO_WIN)) || (p2_score_q == SCORE_W'(ROUNDS_TO_WIN)) ||
              (round_cnt_q == SCORE_W'(MAX_ROUNDS))) begin
            state_d = StDone;
          end else begin
            state_d   = StCollect;
            p1_have_d = 1'b0;
            p2_have_d = 1'b0;
            tmo_d     = '0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      start_q     <= 1'b0;
      p1_have_q   <= 1'b0;
      p2_have_q   <= 1'b0;
      p1_mv_q     <= 2'b00;
      p2_mv_q     <= 2'b00;
      tmo_q       <= '0;
      p1_score_q  <= '0;
      p2_score_q  <= '0;
      round_cnt_q <= '0;
      result_q    <= 2'b00;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= bus.start;
      p1_have_q   <= p1_have_d;
      p2_have_q   <= p2_have_d;
      p1_mv_q     <= p1_mv_d;
      p2_mv_q     <= p2_mv_d;
      tmo_q       <= tmo_d;
      p1_score_q  <= p1_score_d;
      p2_score_q  <= p2_score_d;
      round_cnt_q <= round_cnt_d;
      result_q    <= result_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    bus.match_winner = 2'b00;
    if (state_q == StDone) begin
      if (p1_score_q > p2_score_q) bus.match_winner = 2'b01;
      else if (p2_score_q > p1_score_q) bus.match_winner = 2'b10;
    end
  end

  assign bus.p1_ready     = p1_rdy;
  assign bus.p2_ready     = p2_rdy;
  assign bus.round_done   = (state_q == StCheck);
  assign bus.round_result = result_q;
  assign bus.p1_score     = p1_score_q;
  assign bus.p2_score     = p2_score_q;
  assign bus.round_cnt    = round_cnt_q;
  assign bus.match_done   = (state_q == StDone);
  assign bus.err_invalid  = err_q;
  assign bus.state_o      = state_q;

endmodule
